// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target bridging host transfers onto a simple register bus
// Optional SCL/SDA glitch filter enabled by defining I2C_GLITCH_FILTER_EN.
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR    = 7'h3C,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT_LEN    = 3
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_wr_o,
    output logic       reg_rd_o,
    input  logic [7:0] reg_rdata_i,
    output logic       busy_o
);

    localparam int NSYNC = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

`ifdef I2C_GLITCH_FILTER_EN
    localparam int FILT_DEPTH = FILT_LEN;
`else
    localparam int FILT_DEPTH = 0 * FILT_LEN;
`endif

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_ADDR     = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK = 4'd2;
    localparam logic [3:0] ST_WR_PTR   = 4'd3;
    localparam logic [3:0] ST_PTR_ACK  = 4'd4;
    localparam logic [3:0] ST_WR_DATA  = 4'd5;
    localparam logic [3:0] ST_DATA_ACK = 4'd6;
    localparam logic [3:0] ST_RD_DATA  = 4'd7;
    localparam logic [3:0] ST_RD_ACK   = 4'd8;
    localparam logic [3:0] ST_IGNORE   = 4'd9;

    // Synchronizers reset to the idle-bus level so reset release creates no edges
    logic [NSYNC-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic             scl_s, sda_s;

    always_comb begin
        scl_sync_d = {scl_sync_q[NSYNC-2:0], scl_i};
        sda_sync_d = {sda_sync_q[NSYNC-2:0], sda_i};
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
        end
    end

    generate
        if (FILT_DEPTH > 0) begin : g_filt
            localparam int            CW      = $clog2(FILT_DEPTH + 1);
            localparam logic [CW-1:0] CNT_MAX = CW'(FILT_DEPTH - 1);
            logic          scl_f_q, scl_f_d, sda_f_q, sda_f_d;
            logic [CW-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;

            // Output follows the input only after FILT_DEPTH consecutive differing samples
            always_comb begin
                scl_f_d   = scl_f_q;
                scl_cnt_d = '0;
                sda_f_d   = sda_f_q;
                sda_cnt_d = '0;
                if (scl_sync_q[NSYNC-1] != scl_f_q) begin
                    if (scl_cnt_q == CNT_MAX) scl_f_d = scl_sync_q[NSYNC-1];
                    else                      scl_cnt_d = scl_cnt_q + 1'b1;
                end
                if (sda_sync_q[NSYNC-1] != sda_f_q) begin
                    if (sda_cnt_q == CNT_MAX) sda_f_d = sda_sync_q[NSYNC-1];
                    else                      sda_cnt_d = sda_cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) begin
                    scl_f_q   <= 1'b1;
                    sda_f_q   <= 1'b1;
                    scl_cnt_q <= '0;
                    sda_cnt_q <= '0;
                end else begin
                    scl_f_q   <= scl_f_d;
                    sda_f_q   <= sda_f_d;
                    scl_cnt_q <= scl_cnt_d;
                    sda_cnt_q <= sda_cnt_d;
                end
            end

            assign scl_s = scl_f_q;
            assign sda_s = sda_f_q;
        end else begin : g_nofilt
            assign scl_s = scl_sync_q[NSYNC-1];
            assign sda_s = sda_sync_q[NSYNC-1];
        end
    endgenerate

    logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic       start_det, stop_det, scl_rise, scl_fall;
    logic [3:0] state_q, state_d, bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d, ptr_q, ptr_d, wdata_q, wdata_d;
    logic       wr_q, wr_d, rd_q, rd_d, rd_dly_q, rd_dly_d;
    logic       sda_oe_q, sda_oe_d, busy_q, busy_d, mack_q, mack_d;

    always_comb begin
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
        start_det  = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
        stop_det   = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
        scl_rise   = scl_s & ~scl_prev_q;
        scl_fall   = ~scl_s & scl_prev_q;
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        wdata_d   = wdata_q;
        wr_d      = 1'b0;
        rd_d      = 1'b0;
        rd_dly_d  = rd_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        mack_d    = mack_q;

        // Pointer advances the cycle after a strobe so reg_addr_o is stable during it
        if (wr_q || rd_dly_q) ptr_d = ptr_q + 8'd1;
        if (rd_dly_q) begin
            shift_d  = reg_rdata_i;
            sda_oe_d = ~reg_rdata_i[7];
        end

        if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_WR_PTR, ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[6:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b1;
                        if (state_q == ST_ADDR) begin
                            if (shift_q[7:1] == DEV_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                busy_d  = 1'b1;
                            end else begin
                                state_d  = ST_IGNORE;
                                sda_oe_d = 1'b0;
                                busy_d   = 1'b0;
                            end
                        end else if (state_q == ST_WR_PTR) begin
                            state_d = ST_PTR_ACK;
                            ptr_d   = shift_q;
                        end else begin
                            state_d = ST_DATA_ACK;
                            wr_d    = 1'b1;
                            wdata_d = shift_q;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        if (shift_q[0]) begin
                            state_d = ST_RD_DATA;
                            rd_d    = 1'b1;
                        end else begin
                            state_d = ST_WR_PTR;
                        end
                    end
                end
                ST_PTR_ACK, ST_DATA_ACK: begin
                    if (scl_fall) begin
                        state_d   = ST_WR_DATA;
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        state_d  = ST_RD_ACK;
                        sda_oe_d = 1'b0;
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        mack_d = ~sda_s;
                    end else if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (mack_q) begin
                            state_d = ST_RD_DATA;
                            rd_d    = 1'b1;
                        end else begin
                            state_d  = ST_IGNORE;
                            sda_oe_d = 1'b0;
                            busy_d   = 1'b0;
                        end
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            ptr_q      <= 8'h00;
            wdata_q    <= 8'h00;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            rd_dly_q   <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            mack_q     <= 1'b0;
        end else begin
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            rd_dly_q   <= rd_dly_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            mack_q     <= mack_d;
        end
    end

    assign sda_oe_o    = sda_oe_q;
    assign reg_addr_o  = ptr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_wr_o    = wr_q;
    assign reg_rd_o    = rd_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - directed I2C master transfers against i2c_target_regs
module tb_i2c_target_regs;

    localparam int Q = 10;

    logic       clk;
    logic       reset_i;
    logic       scl_m, sda_m;
    logic       sda_bus;
    logic       sda_oe_o;
    logic [7:0] reg_addr_o, reg_wdata_o, reg_rdata;
    logic       reg_wr_o, reg_rd_o, busy_o;

    int n_checks = 0;
    int n_fails  = 0;
    int rd_cnt   = 0;
    int oe_cnt   = 0;
    logic [7:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];

    assign sda_bus = sda_m & ~sda_oe_o;

    i2c_target_regs dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .scl_i      (scl_m),
        .sda_i      (sda_bus),
        .sda_oe_o   (sda_oe_o),
        .reg_addr_o (reg_addr_o),
        .reg_wdata_o(reg_wdata_o),
        .reg_wr_o   (reg_wr_o),
        .reg_rd_o   (reg_rd_o),
        .reg_rdata_i(reg_rdata),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-bus host: records writes, returns 0x80+addr one cycle after a read strobe
    always @(negedge clk) begin
        if (reg_wr_o) begin
            wr_addr_q.push_back(reg_addr_o);
            wr_data_q.push_back(reg_wdata_o);
        end
        if (reg_rd_o) begin
            rd_cnt++;
            reg_rdata <= 8'h80 + reg_addr_o;
        end
        if (sda_oe_o) oe_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; hold(Q);
        scl_m = 1'b1; hold(Q);
        sda_m = 1'b0; hold(Q);
        scl_m = 1'b0; hold(Q);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; hold(Q);
        scl_m = 1'b1; hold(Q);
        sda_m = 1'b1; hold(Q);
    endtask

    task automatic put_bit(input logic b);
        sda_m = b;    hold(Q);
        scl_m = 1'b1; hold(2 * Q);
        scl_m = 1'b0; hold(Q);
    endtask

    task automatic get_ack(output logic ack_n);
        sda_m = 1'b1; hold(Q);
        scl_m = 1'b1; hold(Q);
        ack_n = sda_bus; hold(Q);
        scl_m = 1'b0; hold(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack_n);
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        get_ack(ack_n);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] b);
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            hold(Q);
            scl_m = 1'b1; hold(Q);
            b[i] = sda_bus; hold(Q);
            scl_m = 1'b0;
        end
        hold(Q);
        put_bit(~ack);
        sda_m = 1'b1;
    endtask

    initial begin
        logic       ack_n;
        logic [7:0] rb;
        int         wb, rb0, ob;
        logic [7:0] b6;

        reset_i = 1'b1;
        scl_m   = 1'b1;
        sda_m   = 1'b1;
        hold(4);
        reset_i = 1'b0;
        hold(4);
        check_eq("rst_sda_oe", sda_oe_o, 0);
        check_eq("rst_wr", reg_wr_o, 0);
        check_eq("rst_rd", reg_rd_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_ptr", reg_addr_o, 8'h00);

        // 1: pointer 0x10, two data bytes
        wb = wr_addr_q.size();
        i2c_start();
        write_byte(8'h78, ack_n); check_eq("t1_ack_addr", ack_n, 0);
        check_eq("t1_busy", busy_o, 1);
        write_byte(8'h10, ack_n); check_eq("t1_ack_ptr", ack_n, 0);
        write_byte(8'hA5, ack_n); check_eq("t1_ack_d0", ack_n, 0);
        write_byte(8'h5A, ack_n); check_eq("t1_ack_d1", ack_n, 0);
        i2c_stop();
        check_eq("t1_busy_end", busy_o, 0);
        check_eq("t1_nwr", wr_addr_q.size() - wb, 2);
        check_eq("t1_wa0", wr_addr_q[wb], 8'h10);
        check_eq("t1_wd0", wr_data_q[wb], 8'hA5);
        check_eq("t1_wa1", wr_addr_q[wb+1], 8'h11);
        check_eq("t1_wd1", wr_data_q[wb+1], 8'h5A);
        check_eq("t1_ptr", reg_addr_o, 8'h12);
        hold(2 * Q);

        // 2: pointer 0x20, repeated START, read three bytes
        wb  = wr_addr_q.size();
        rb0 = rd_cnt;
        i2c_start();
        write_byte(8'h78, ack_n); check_eq("t2_ack_addr", ack_n, 0);
        write_byte(8'h20, ack_n); check_eq("t2_ack_ptr", ack_n, 0);
        i2c_start();
        write_byte(8'h79, ack_n); check_eq("t2_ack_raddr", ack_n, 0);
        read_byte(1'b1, rb); check_eq("t2_rd0", rb, 8'hA0);
        read_byte(1'b1, rb); check_eq("t2_rd1", rb, 8'hA1);
        read_byte(1'b0, rb); check_eq("t2_rd2", rb, 8'hA2);
        hold(Q);
        check_eq("t2_oe_nack", sda_oe_o, 0);
        check_eq("t2_busy_nack", busy_o, 0);
        i2c_stop();
        check_eq("t2_nrd", rd_cnt - rb0, 3);
        check_eq("t2_nwr", wr_addr_q.size() - wb, 0);
        check_eq("t2_ptr", reg_addr_o, 8'h23);
        hold(2 * Q);

        // 3: foreign address
        wb  = wr_addr_q.size();
        rb0 = rd_cnt;
        ob  = oe_cnt;
        i2c_start();
        write_byte(8'h7A, ack_n); check_eq("t3_nack_addr", ack_n, 1);
        check_eq("t3_busy", busy_o, 0);
        write_byte(8'h55, ack_n); check_eq("t3_nack_data", ack_n, 1);
        i2c_stop();
        check_eq("t3_oe_cnt", oe_cnt - ob, 0);
        check_eq("t3_nwr", wr_addr_q.size() - wb, 0);
        check_eq("t3_nrd", rd_cnt - rb0, 0);
        hold(2 * Q);

        // 4: pointer wrap 0xFF -> 0x00
        wb = wr_addr_q.size();
        i2c_start();
        write_byte(8'h78, ack_n); check_eq("t4_ack_addr", ack_n, 0);
        write_byte(8'hFF, ack_n); check_eq("t4_ack_ptr", ack_n, 0);
        write_byte(8'h11, ack_n); check_eq("t4_ack_d0", ack_n, 0);
        write_byte(8'h22, ack_n); check_eq("t4_ack_d1", ack_n, 0);
        i2c_stop();
        check_eq("t4_nwr", wr_addr_q.size() - wb, 2);
        check_eq("t4_wa0", wr_addr_q[wb], 8'hFF);
        check_eq("t4_wd0", wr_data_q[wb], 8'h11);
        check_eq("t4_wa1", wr_addr_q[wb+1], 8'h00);
        check_eq("t4_wd1", wr_data_q[wb+1], 8'h22);
        check_eq("t4_ptr", reg_addr_o, 8'h01);
        hold(2 * Q);

        // 5: reset while the pointer byte ACK is being driven
        wb = wr_addr_q.size();
        i2c_start();
        write_byte(8'h78, ack_n); check_eq("t5_ack_addr", ack_n, 0);
        for (int i = 7; i >= 0; i--) put_bit(b6_const(i));
        sda_m = 1'b1; hold(Q);
        scl_m = 1'b1; hold(Q / 2);
        check_eq("t5_oe_pre", sda_oe_o, 1);
        reset_i = 1'b1;
        #1;
        check_eq("t5_oe_rst", sda_oe_o, 0);
        check_eq("t5_ptr_rst", reg_addr_o, 8'h00);
        check_eq("t5_busy_rst", busy_o, 0);
        hold(3);
        reset_i = 1'b0;
        hold(Q);
        scl_m = 1'b0; hold(Q);
        i2c_stop();
        hold(2 * Q);
        i2c_start();
        write_byte(8'h78, ack_n); check_eq("t5_ack_addr2", ack_n, 0);
        write_byte(8'h33, ack_n); check_eq("t5_ack_ptr", ack_n, 0);
        write_byte(8'h44, ack_n); check_eq("t5_ack_d0", ack_n, 0);
        i2c_stop();
        check_eq("t5_nwr", wr_addr_q.size() - wb, 1);
        check_eq("t5_wa0", wr_addr_q[wb], 8'h33);
        check_eq("t5_wd0", wr_data_q[wb], 8'h44);
        hold(2 * Q);

        // 6: 2-cycle SCL low glitch inside the first address bit
        wb = wr_addr_q.size();
        b6 = 8'h78;
        i2c_start();
        sda_m = b6[7]; hold(Q);
        scl_m = 1'b1;  hold(5);
        scl_m = 1'b0;  hold(2);
        scl_m = 1'b1;  hold(2 * Q - 7);
        scl_m = 1'b0;  hold(Q);
        for (int i = 6; i >= 0; i--) put_bit(b6[i]);
        get_ack(ack_n);
`ifdef I2C_GLITCH_FILTER_EN
        check_eq("t6_glitch_ack", ack_n, 0);
`else
        check_eq("t6_glitch_ack", ack_n, 1);
`endif
        i2c_stop();
        check_eq("t6_busy_end", busy_o, 0);
        check_eq("t6_nwr", wr_addr_q.size() - wb, 0);
        hold(2 * Q);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    function automatic logic b6_const(input int i);
        logic [7:0] v;
        v = 8'h40;
        return v[i];
    endfunction

endmodule
